// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with line prefetch request
module vga_timing_gen #(
   parameter int   CLK_DIV    = 2,
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 33,
   parameter logic HS_POL     = 1'b0,
   parameter logic VS_POL     = 1'b0,
   parameter int   FETCH_LEAD = 32,
   parameter int   X_W        = 10,
   parameter int   Y_W        = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic           pix_ce,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           valid,
   output logic           hsync,
   output logic           vsync,
   output logic           newline,
   output logic           newframe,
   output logic [15:0]    frame_cnt,
   output logic           line_req,
   output logic [Y_W-1:0] line_req_y
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0]   X_REQ    = X_W'(H_TOTAL - FETCH_LEAD - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);

   if ((H_TOTAL - 1) >= (1 << X_W) || (V_TOTAL - 1) >= (1 << Y_W)) begin : g_width_check
      $error("vga_timing_gen: X_W/Y_W too narrow for the raster");
   end
   if (CLK_DIV < 1 || FETCH_LEAD < 1 || FETCH_LEAD > H_TOTAL - 1) begin : g_param_check
      $error("vga_timing_gen: CLK_DIV or FETCH_LEAD out of range");
   end

   logic [DIV_W-1:0] div;
   logic             pix_q;
   logic             newline_q;
   logic             newframe_q;
   logic             line_req_q;
   logic [Y_W-1:0]   next_row;
   logic             row_ok;

   // Strobe registers freeze with the timing; gating keeps them silent while en is low.
   assign pix_ce   = pix_q & en;
   assign newline  = newline_q & en;
   assign newframe = newframe_q & en;
   assign line_req = line_req_q & en;

   assign next_row = (y == Y_LAST) ? '0 : y + Y_W'(1);
   assign row_ok   = int'(next_row) < V_ACTIVE;

   assign valid = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
   assign hsync = (int'(x) >= HS_START && int'(x) < HS_END) ? HS_POL : ~HS_POL;
   assign vsync = (int'(y) >= VS_START && int'(y) < VS_END) ? VS_POL : ~VS_POL;

   always_ff @(posedge clk) begin
      if (rst) begin
         div        <= '0;
         pix_q      <= 1'b0;
         x          <= '0;
         y          <= '0;
         frame_cnt  <= '0;
         newline_q  <= 1'b1;
         newframe_q <= 1'b1;
         line_req_q <= 1'b0;
         line_req_y <= '0;
      end else if (en) begin
         div        <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
         pix_q      <= (div == DIV_LAST);
         newline_q  <= 1'b0;
         newframe_q <= 1'b0;
         line_req_q <= 1'b0;
         if (pix_q) begin
            if (x == X_LAST) begin
               x         <= '0;
               newline_q <= 1'b1;
               if (y == Y_LAST) begin
                  y          <= '0;
                  newframe_q <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
               end else begin
                  y <= y + Y_W'(1);
               end
            end else begin
               x <= x + X_W'(1);
            end
            // X_REQ never equals X_LAST, so next_row still refers to the current line.
            if (x == X_REQ && row_ok) begin
               line_req_q <= 1'b1;
               line_req_y <= next_row;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a pixel-index model
module tb_vga_timing_gen;

   typedef struct packed {
      logic        pix_ce;
      logic [15:0] x;
      logic [15:0] y;
      logic        valid;
      logic        hsync;
      logic        vsync;
      logic        newline;
      logic        newframe;
      logic [15:0] frame_cnt;
      logic        line_req;
      logic [15:0] line_req_y;
   } obs_t;

   typedef struct {
      int div, ha, hfp, hs, hbp, va, vfp, vs, vbp, fl;
      bit hpol, vpol;
   } cfg_t;

   typedef struct {
      longint e, p, last_nl, last_nf, last_lr;
      int     req_row;
   } mst_t;

   logic clk = 1'b0;
   logic rst;
   logic en;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: medium raster, divide by 2, active-low syncs.
   logic        a_pix_ce, a_valid, a_hsync, a_vsync, a_newline, a_newframe, a_line_req;
   logic [5:0]  a_x;
   logic [4:0]  a_y, a_line_req_y;
   logic [15:0] a_frame_cnt;

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_LEAD(6), .X_W(6), .Y_W(5)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .pix_ce(a_pix_ce), .x(a_x), .y(a_y),
      .valid(a_valid), .hsync(a_hsync), .vsync(a_vsync), .newline(a_newline),
      .newframe(a_newframe), .frame_cnt(a_frame_cnt), .line_req(a_line_req),
      .line_req_y(a_line_req_y)
   );

   // Instance B: tiny 8x4 raster, no divider, active-high syncs, zero vertical back porch.
   logic        b_pix_ce, b_valid, b_hsync, b_vsync, b_newline, b_newframe, b_line_req;
   logic [2:0]  b_x;
   logic [1:0]  b_y, b_line_req_y;
   logic [15:0] b_frame_cnt;

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(0),
      .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LEAD(3), .X_W(3), .Y_W(2)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .pix_ce(b_pix_ce), .x(b_x), .y(b_y),
      .valid(b_valid), .hsync(b_hsync), .vsync(b_vsync), .newline(b_newline),
      .newframe(b_newframe), .frame_cnt(b_frame_cnt), .line_req(b_line_req),
      .line_req_y(b_line_req_y)
   );

   obs_t ga, gb;
   assign ga = {a_pix_ce, 16'(a_x), 16'(a_y), a_valid, a_hsync, a_vsync, a_newline,
                a_newframe, a_frame_cnt, a_line_req, 16'(a_line_req_y)};
   assign gb = {b_pix_ce, 16'(b_x), 16'(b_y), b_valid, b_hsync, b_vsync, b_newline,
                b_newframe, b_frame_cnt, b_line_req, 16'(b_line_req_y)};

   obs_t qa[$];
   obs_t qb[$];

   function automatic mst_t reset_state();
      mst_t s;
      s.e = 0; s.p = 0; s.last_nl = -1; s.last_nf = -1; s.last_lr = -1; s.req_row = 0;
      return s;
   endfunction

   // Is pixel index p the position where the prefetch for the following row is due?
   function automatic bit req_at(cfg_t c, longint p);
      longint ht = c.ha + c.hfp + c.hs + c.hbp;
      longint vt = c.va + c.vfp + c.vs + c.vbp;
      longint yy = (p / ht) % vt;
      return ((p % ht) == ht - c.fl) && (((yy + 1) % vt) < c.va);
   endfunction

   function automatic obs_t predict(cfg_t c, mst_t s, logic en_i);
      obs_t   o;
      longint ht = c.ha + c.hfp + c.hs + c.hbp;
      longint vt = c.va + c.vfp + c.vs + c.vbp;
      longint xx = s.p % ht;
      longint ln = s.p / ht;
      longint yy = ln % vt;
      o = '0;
      o.pix_ce     = en_i && (s.e >= c.div) && ((s.e % c.div) == 0);
      o.x          = 16'(xx);
      o.y          = 16'(yy);
      o.frame_cnt  = 16'((ln / vt) % 65536);
      o.valid      = (xx < c.ha) && (yy < c.va);
      o.hsync      = (xx >= c.ha + c.hfp && xx < c.ha + c.hfp + c.hs) ? c.hpol : !c.hpol;
      o.vsync      = (yy >= c.va + c.vfp && yy < c.va + c.vfp + c.vs) ? c.vpol : !c.vpol;
      o.newline    = en_i && (xx == 0) && (s.last_nl != s.p);
      o.newframe   = en_i && (xx == 0) && (yy == 0) && (s.last_nf != s.p);
      o.line_req   = en_i && req_at(c, s.p) && (s.last_lr != s.p);
      o.line_req_y = 16'(s.req_row);
      return o;
   endfunction

   function automatic mst_t step(cfg_t c, mst_t s, logic en_i, logic rst_i, obs_t o);
      mst_t n = s;
      longint ht = c.ha + c.hfp + c.hs + c.hbp;
      longint vt = c.va + c.vfp + c.vs + c.vbp;
      if (rst_i) return reset_state();
      if (en_i) begin
         if (o.newline)  n.last_nl = s.p;
         if (o.newframe) n.last_nf = s.p;
         if (o.line_req) n.last_lr = s.p;
         n.e = s.e + 1;
         if (o.pix_ce) begin
            n.p = s.p + 1;
            if (req_at(c, n.p)) n.req_row = int'(((n.p / ht) + 1) % vt);
         end
      end
      return n;
   endfunction

   initial begin
      forever begin
         obs_t e;
         @(negedge clk);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            checks++;
            if (ga !== e) begin
               errors++;
               if (errors <= 20)
                  $display("FAIL dut_a_cycle t=%0t got=%h want=%h", $time, ga, e);
            end
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            checks++;
            if (gb !== e) begin
               errors++;
               if (errors <= 20)
                  $display("FAIL dut_b_cycle t=%0t got=%h want=%h", $time, gb, e);
            end
         end
      end
   end

   initial begin
      cfg_t ca, cb;
      mst_t sa, sb;
      obs_t ea, eb;
      int   pause_left = 0;
      bit   pause_done = 0;
      bit   rst_done   = 0;
      logic rst_v, en_v;
      longint ax, ay;

      ca = '{div: 2, ha: 40, hfp: 4, hs: 8, hbp: 4, va: 12, vfp: 2, vs: 2, vbp: 3, fl: 6,
             hpol: 1'b0, vpol: 1'b0};
      cb = '{div: 1, ha: 4, hfp: 1, hs: 2, hbp: 1, va: 2, vfp: 1, vs: 1, vbp: 0, fl: 3,
             hpol: 1'b1, vpol: 1'b1};
      sa = reset_state();
      sb = reset_state();

      rst = 1'b1;
      en  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int cyc = 0; cyc < 12000; cyc++) begin
         ax = sa.p % 56;
         ay = (sa.p / 56) % 19;
         rst_v = 1'b0;
         en_v  = 1'b1;
         if (cyc < 5400) begin
            if (!pause_done && cyc >= 1000 && ax == 20) begin
               pause_done = 1;
               pause_left = 10;
            end
            if (pause_left > 0) begin
               en_v = 1'b0;
               pause_left--;
            end
            if (!rst_done && cyc >= 4400 && ax == 30 && ay == 8) begin
               rst_done = 1;
               rst_v    = 1'b1;
               checks++;
               if (a_frame_cnt !== 16'd2) begin
                  errors++;
                  $display("FAIL frame_cnt_before_rst got=%0d want=2", a_frame_cnt);
               end
            end
         end else begin
            en_v  = ($urandom_range(3, 0) != 0);
            rst_v = ($urandom_range(1999, 0) == 0);
         end
         rst = rst_v;
         en  = en_v;
         ea = predict(ca, sa, en_v);
         eb = predict(cb, sb, en_v);
         qa.push_back(ea);
         qb.push_back(eb);
         sa = step(ca, sa, en_v, rst_v, ea);
         sb = step(cb, sb, en_v, rst_v, eb);
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left_a=%0d left_b=%0d want=0", qa.size(), qb.size());
      end
      checks++;
      if (!rst_done || !pause_done) begin
         errors++;
         $display("FAIL directed_events rst=%0d pause=%0d want=1", rst_done, pause_done);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
